tt_lut_prog: RTL

- Parametrised, runtime-programmable N-input truth-table gate: the successor to the fixed 3-input truth-table gate modules.
- The active truth table is loaded serially over a valid/ready stream and committed atomically, so a half-loaded table is never visible at the output.
- Output is registered and updates only after the input vector has been stable for a programmable number of cycles, modelling gate settling time.
- Sits wherever a circuit netlist needs a logic gate whose function is chosen at runtime rather than at synthesis.

---
 rtl/tt_lut_pkg.sv | 18 +
 rtl/tt_settle_filter.sv | 40 ++++
 rtl/tt_lut_prog.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tt_lut_pkg.sv
// Shared types and sizing helpers for the programmable truth-table gate.
// No logic here; imported by the gate top and its settle filter.
package tt_lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    localparam int MAX_N_IN = 6;
    localparam int MAX_TT_W = 64;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_filter.sv
// Input stability filter: stable_pulse fires once, HOLD_CYC edges after in_vec is captured and held.
// Any change of in_vec restarts the count; no backpressure.
module tt_settle_filter #(
    parameter int W        = 3,
    parameter int HOLD_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_vec,
    output logic [W-1:0] in_q,
    output logic         stable_pulse,
    output logic         stable
);

    localparam int CW = $clog2(HOLD_CYC + 1);
    localparam logic [CW-1:0] HOLD    = CW'(HOLD_CYC);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYC - 1);

    logic [CW-1:0] stab_cnt;
    logic          same;

    assign same = (in_vec == in_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q     <= '0;
            stab_cnt <= '0;
        end else if (!same) begin
            in_q     <= in_vec;
            stab_cnt <= '0;
        end else if (stab_cnt != HOLD) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // The count only reaches HOLD by passing HOLD_M1, so either value means settled.
    assign stable_pulse = same && (stab_cnt == HOLD_M1);
    assign stable       = same && ((stab_cnt == HOLD_M1) || (stab_cnt == HOLD));

endmodule

// File: rtl/tt_lut_prog.sv
// Runtime-programmable N-input truth-table gate with serial, atomically committed table load.
// Output registered, updates HOLD_CYC edges after in_vec settles; cfg_ready drops for the commit cycle.
module tt_lut_prog
    import tt_lut_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int HOLD_CYC = 2,
    parameter logic [tt_width(N_IN)-1:0] RESET_TT = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in_vec,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            cfg_bit,
    input  logic            cfg_abort,
    output logic            cfg_done,
    output logic            loading,
    output logic            out,
    output logic            out_settled
);

    localparam int TT_W  = tt_width(N_IN);
    localparam int CNT_W = $clog2(TT_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TT_W);

    cfg_state_e      state;
    logic [TT_W-1:0] shadow;
    logic [TT_W-1:0] active_tt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic            beat;
    logic [N_IN-1:0] in_q;
    logic            stable_pulse;
    logic            stable;
    logic            refresh;

    assign beat    = cfg_valid && cfg_ready;
    assign cnt_nxt = bit_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            bit_cnt   <= '0;
            active_tt <= RESET_TT;
            cfg_ready <= 1'b1;
            cfg_done  <= 1'b0;
            loading   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat) begin
                        shadow  <= {shadow[TT_W-2:0], cfg_bit};
                        bit_cnt <= cnt_nxt;
                        if (cnt_nxt == LAST_CNT) begin
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
                            cfg_done  <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            loading <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        loading <= 1'b0;
                    end else if (beat) begin
                        shadow  <= {shadow[TT_W-2:0], cfg_bit};
                        bit_cnt <= cnt_nxt;
                        if (cnt_nxt == LAST_CNT) begin
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
                            cfg_done  <= 1'b1;
                            loading   <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    active_tt <= shadow;
                    bit_cnt   <= '0;
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    loading   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    cfg_ready <= 1'b1;
                    loading   <= 1'b0;
                end
            endcase
        end
    end

    tt_settle_filter #(
        .W        (N_IN),
        .HOLD_CYC (HOLD_CYC)
    ) u_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vec       (in_vec),
        .in_q         (in_q),
        .stable_pulse (stable_pulse),
        .stable       (stable)
    );

    // A commit over a settled input re-arms a one-shot refresh so the new table is
    // looked up on the edge after active_tt has actually changed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out         <= 1'b0;
            out_settled <= 1'b0;
            refresh     <= 1'b0;
        end else if (in_vec != in_q) begin
            out_settled <= 1'b0;
            refresh     <= 1'b0;
        end else if ((state == COMMIT) && stable) begin
            out_settled <= 1'b0;
            refresh     <= 1'b1;
        end else if (stable_pulse || refresh) begin
            out         <= active_tt[in_q];
            out_settled <= 1'b1;
            refresh     <= 1'b0;
        end
    end

endmodule
